// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoder control, register-file data and stage status.
// master = ID side / environment driving id* and consuming ex*; slave = the pipeline register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              exHold;
  logic              flush;
  logic              idValid;
  logic [1:0]        idAluOp;
  logic              idRegDst;
  logic              idAluSrc;
  logic              idMemToReg;
  logic              idRegWrite;
  logic              idMemWrite;
  logic              idMemRead;
  logic              idBranch;
  logic [REG_AW-1:0] idRs;
  logic [REG_AW-1:0] idRt;
  logic [REG_AW-1:0] idRd;
  logic [DATA_W-1:0] idReadData1;
  logic [DATA_W-1:0] idReadData2;
  logic [DATA_W-1:0] idSignImm;
  logic [DATA_W-1:0] idPcPlus4;

  logic              exValid;
  logic [1:0]        exAluOp;
  logic              exRegDst;
  logic              exAluSrc;
  logic              exMemToReg;
  logic              exRegWrite;
  logic              exMemWrite;
  logic              exMemRead;
  logic              exBranch;
  logic [REG_AW-1:0] exRs;
  logic [REG_AW-1:0] exRt;
  logic [REG_AW-1:0] exRd;
  logic [DATA_W-1:0] exReadData1;
  logic [DATA_W-1:0] exReadData2;
  logic [DATA_W-1:0] exSignImm;
  logic [DATA_W-1:0] exPcPlus4;
  logic              hazardStall;
  logic [CNT_W-1:0]  bubbleCount;

  modport master (
    output exHold, flush, idValid, idAluOp, idRegDst, idAluSrc, idMemToReg,
           idRegWrite, idMemWrite, idMemRead, idBranch, idRs, idRt, idRd,
           idReadData1, idReadData2, idSignImm, idPcPlus4,
    input  exValid, exAluOp, exRegDst, exAluSrc, exMemToReg, exRegWrite,
           exMemWrite, exMemRead, exBranch, exRs, exRt, exRd, exReadData1,
           exReadData2, exSignImm, exPcPlus4, hazardStall, bubbleCount
  );

  modport slave (
    input  exHold, flush, idValid, idAluOp, idRegDst, idAluSrc, idMemToReg,
           idRegWrite, idMemWrite, idMemRead, idBranch, idRs, idRt, idRd,
           idReadData1, idReadData2, idSignImm, idPcPlus4,
    output exValid, exAluOp, exRegDst, exAluSrc, exMemToReg, exRegWrite,
           exMemWrite, exMemRead, exBranch, exRs, exRt, exRd, exReadData1,
           exReadData2, exSignImm, exPcPlus4, hazardStall, bubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// count of hazard bubbles. Priority per edge: reset, hold, flush, hazard, load.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic idUsesRt;
  logic hazard;
  logic insertBubble;

  // Load-use detection: the load in EX writes a register the ID instruction reads; $0 is exempt.
  always_comb begin
    idUsesRt = !bus.idAluSrc | bus.idMemWrite;
    hazard   = bus.exValid & bus.exMemRead & bus.idValid & !bus.flush &
               (bus.exRt != '0) &
               ((bus.exRt == bus.idRs) | (idUsesRt & (bus.exRt == bus.idRt)));
    insertBubble = !bus.exHold & (bus.flush | hazard);
  end

  assign bus.hazardStall = hazard;

  // Pipeline register: clear on reset or bubble, freeze on hold, otherwise load
  // (control gated off for an invalid slot so it can never store or write back).
  always_ff @(posedge clk) begin
    if (rst || insertBubble) begin
      bus.exValid     <= 1'b0;
      bus.exAluOp     <= 2'b00;
      bus.exRegDst    <= 1'b0;
      bus.exAluSrc    <= 1'b0;
      bus.exMemToReg  <= 1'b0;
      bus.exRegWrite  <= 1'b0;
      bus.exMemWrite  <= 1'b0;
      bus.exMemRead   <= 1'b0;
      bus.exBranch    <= 1'b0;
      bus.exRs        <= '0;
      bus.exRt        <= '0;
      bus.exRd        <= '0;
      bus.exReadData1 <= '0;
      bus.exReadData2 <= '0;
      bus.exSignImm   <= '0;
      bus.exPcPlus4   <= '0;
    end else if (!bus.exHold) begin
      bus.exValid     <= bus.idValid;
      bus.exAluOp     <= bus.idValid ? bus.idAluOp : 2'b00;
      bus.exRegDst    <= bus.idValid & bus.idRegDst;
      bus.exAluSrc    <= bus.idValid & bus.idAluSrc;
      bus.exMemToReg  <= bus.idValid & bus.idMemToReg;
      bus.exRegWrite  <= bus.idValid & bus.idRegWrite;
      bus.exMemWrite  <= bus.idValid & bus.idMemWrite;
      bus.exMemRead   <= bus.idValid & bus.idMemRead;
      bus.exBranch    <= bus.idValid & bus.idBranch;
      bus.exRs        <= bus.idRs;
      bus.exRt        <= bus.idRt;
      bus.exRd        <= bus.idRd;
      bus.exReadData1 <= bus.idReadData1;
      bus.exReadData2 <= bus.idReadData2;
      bus.exSignImm   <= bus.idSignImm;
      bus.exPcPlus4   <= bus.idPcPlus4;
    end
  end

  // Bubble statistics: count only hazard bubbles (not flushes), saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bubbleCount <= '0;
    end else if (!bus.exHold && hazard && (bus.bubbleCount != '1)) begin
      bus.bubbleCount <= bus.bubbleCount + CNT_W'(1);
    end
  end

endmodule
